// File: rtl/alu_seq_acc.sv
// rtl/alu_seq_acc.sv - registered, parametrised ALU with accumulator, valid/ready handshake and error flags
module alu_seq_acc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opCode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             error,
   output logic             err_sticky,
   output logic [WIDTH-1:0] acc
);

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_RESET = 4'b0001;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_ADD   = 4'b0110;
   localparam logic [3:0] OP_SUB   = 4'b1000;
   localparam logic [3:0] OP_EQ    = 4'b1100;
   localparam logic [3:0] OP_GT    = 4'b1101;
   localparam logic [3:0] OP_LT    = 4'b1110;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             overflow_q, overflow_d;
   logic             error_q, error_d;
   logic             err_sticky_q, err_sticky_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;

   logic [WIDTH-1:0] op_res;
   logic             op_carry;
   logic             op_ovf;
   logic             op_err;
   logic             op_beat;
   logic             op_acc_wr;
   logic             op_clr_sticky;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // The accumulator value seen here is the pre-edge value, so chained use_acc ops see the previous result.
   assign op_a   = use_acc ? acc_q : a;
   assign sum_w  = {1'b0, op_a} + {1'b0, b};
   assign diff_w = {1'b0, op_a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      op_res        = '0;
      op_carry      = 1'b0;
      op_ovf        = 1'b0;
      op_err        = 1'b0;
      op_beat       = 1'b1;
      op_acc_wr     = 1'b0;
      op_clr_sticky = 1'b0;
      case (opCode)
         OP_NOOP: begin
            op_beat = 1'b0;
         end
         OP_RESET: begin
            op_acc_wr     = 1'b1;
            op_clr_sticky = 1'b1;
         end
         OP_OR: begin
            op_res    = op_a | b;
            op_acc_wr = 1'b1;
         end
         OP_AND: begin
            op_res    = op_a & b;
            op_acc_wr = 1'b1;
         end
         OP_ADD: begin
            op_res    = sum_w[WIDTH-1:0];
            op_carry  = sum_w[WIDTH];
            op_ovf    = (op_a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != op_a[WIDTH-1]);
            op_acc_wr = 1'b1;
         end
         OP_SUB: begin
            op_res    = diff_w[WIDTH-1:0];
            op_carry  = diff_w[WIDTH];
            op_ovf    = (op_a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != op_a[WIDTH-1]);
            op_acc_wr = 1'b1;
         end
         OP_EQ: begin
            op_res = {{(WIDTH-1){1'b0}}, (op_a == b)};
         end
         OP_GT: begin
            op_res = {{(WIDTH-1){1'b0}}, (op_a > b)};
         end
         OP_LT: begin
            op_res = {{(WIDTH-1){1'b0}}, (op_a < b)};
         end
         default: begin
            op_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      result_d     = result_q;
      zero_d       = zero_q;
      carry_d      = carry_q;
      overflow_d   = overflow_q;
      error_d      = error_q;
      err_sticky_d = err_sticky_q;
      acc_d        = acc_q;
      if (accept) begin
         // A NOOP is only accepted when any held beat leaves this cycle, so the register simply empties.
         if (op_beat) begin
            out_valid_d = 1'b1;
            result_d    = op_res;
            zero_d      = (op_res == '0);
            carry_d     = op_carry;
            overflow_d  = op_ovf;
            error_d     = op_err;
         end else begin
            out_valid_d = 1'b0;
         end
         if (op_acc_wr) begin
            acc_d = op_res;
         end
         if (op_clr_sticky) begin
            err_sticky_d = 1'b0;
         end else if (op_err) begin
            err_sticky_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         zero_q       <= 1'b1;
         carry_q      <= 1'b0;
         overflow_q   <= 1'b0;
         error_q      <= 1'b0;
         err_sticky_q <= 1'b0;
         acc_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         carry_q      <= carry_d;
         overflow_q   <= overflow_d;
         error_q      <= error_d;
         err_sticky_q <= err_sticky_d;
         acc_q        <= acc_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign zero       = zero_q;
   assign carry      = carry_q;
   assign overflow   = overflow_q;
   assign error      = error_q;
   assign err_sticky = err_sticky_q;
   assign acc        = acc_q;

endmodule
